// File: rtl/turn_sequencer.sv
// Turn sequencer for an N-player board game: rotates the active player on each
// accepted move edge, counts moves, and detects win/draw end-of-game conditions.
module turn_sequencer #(
    parameter int NUM_PLAYERS = 2,
    parameter int MAX_MOVES   = 9,
    localparam int PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
    localparam int CW = $clog2(MAX_MOVES + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   move_req,
    input  logic [NUM_PLAYERS-1:0] win,
    output logic [PW-1:0]          cur_player,
    output logic [NUM_PLAYERS-1:0] player_sel,
    output logic                   move_ack,
    output logic [CW-1:0]          move_count,
    output logic [1:0]             game_state,
    output logic [PW-1:0]          winner,
    output logic                   game_over
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_WON  = 2'b10,
        S_DRAW = 2'b11
    } state_t;

    localparam logic [PW-1:0]          LAST_P = PW'(NUM_PLAYERS - 1);
    localparam logic [CW-1:0]          MAX_C  = CW'(MAX_MOVES);
    localparam logic [NUM_PLAYERS-1:0] SEL0   = {{(NUM_PLAYERS-1){1'b0}}, 1'b1};

    state_t        state;
    logic          move_q;
    logic          move_edge;
    logic [PW-1:0] first_player;
    logic [PW-1:0] first_next;

    function automatic logic [PW-1:0] next_player(input logic [PW-1:0] p);
        next_player = (p == LAST_P) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [NUM_PLAYERS-1:0] decode(input logic [PW-1:0] p);
        decode = SEL0 << p;
    endfunction

    // Scan from the top so the lowest set index is the one that sticks.
    function automatic logic [PW-1:0] lowest_win(input logic [NUM_PLAYERS-1:0] w);
        lowest_win = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (w[i]) lowest_win = PW'(i);
        end
    endfunction

    assign move_edge  = move_req & ~move_q;
    assign game_state = state;

    // The starting player rotates only when a finished game is restarted.
    always_comb begin
        first_next = first_player;
        if (state == S_WON || state == S_DRAW) first_next = next_player(first_player);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            move_q       <= 1'b0;
            first_player <= '0;
            cur_player   <= '0;
            player_sel   <= SEL0;
            move_ack     <= 1'b0;
            move_count   <= '0;
            winner       <= '0;
            game_over    <= 1'b0;
        end else begin
            move_q   <= move_req;
            move_ack <= 1'b0;
            if (start) begin
                state        <= S_PLAY;
                game_over    <= 1'b0;
                first_player <= first_next;
                cur_player   <= first_next;
                player_sel   <= decode(first_next);
                move_count   <= '0;
                winner       <= '0;
            end else if (state == S_PLAY) begin
                if (|win) begin
                    // A move edge in the same cycle as a win is dropped.
                    state     <= S_WON;
                    game_over <= 1'b1;
                    winner    <= lowest_win(win);
                end else if (move_count == MAX_C) begin
                    state     <= S_DRAW;
                    game_over <= 1'b1;
                end else if (move_edge) begin
                    move_ack   <= 1'b1;
                    move_count <= move_count + CW'(1);
                    cur_player <= next_player(cur_player);
                    player_sel <= decode(next_player(cur_player));
                end
            end
        end
    end

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer: a 2-player instance is scoreboarded on
// every move_ack, and a 3-player instance checks rotation wrap-around.
module tb_turn_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       move_req;
    logic [1:0] win2;
    logic [2:0] win3;

    logic       cur2;
    logic [1:0] sel2;
    logic       ack2;
    logic [3:0] cnt2;
    logic [1:0] gs2;
    logic       winner2;
    logic       over2;

    logic [1:0] cur3;
    logic [2:0] sel3;
    logic       ack3;
    logic [3:0] cnt3;
    logic [1:0] gs3;
    logic [1:0] winner3;
    logic       over3;

    turn_sequencer #(.NUM_PLAYERS(2), .MAX_MOVES(9)) dut2 (
        .clk(clk), .reset(reset), .start(start), .move_req(move_req), .win(win2),
        .cur_player(cur2), .player_sel(sel2), .move_ack(ack2), .move_count(cnt2),
        .game_state(gs2), .winner(winner2), .game_over(over2)
    );

    turn_sequencer #(.NUM_PLAYERS(3), .MAX_MOVES(9)) dut3 (
        .clk(clk), .reset(reset), .start(start), .move_req(move_req), .win(win3),
        .cur_player(cur3), .player_sel(sel3), .move_ack(ack3), .move_count(cnt3),
        .game_state(gs3), .winner(winner3), .game_over(over3)
    );

    always #5 clk = ~clk;

    typedef struct {
        int player;
        int count;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   mp = 0;   // model: current player of the 2-player game
    int   mc = 0;   // model: move count
    int   mf = 0;   // model: first player
    int   m3 = 0;   // model: current player of the 3-player game

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input int st, input int wn);
        check({tag, ":state"}, 32'(gs2), st);
        check({tag, ":cur"}, 32'(cur2), mp);
        check({tag, ":sel"}, 32'(sel2), 1 << mp);
        check({tag, ":count"}, 32'(cnt2), mc);
        check({tag, ":winner"}, 32'(winner2), wn);
        check({tag, ":over"}, 32'(over2), (st >= 2) ? 1 : 0);
    endtask

    task automatic expect_move();
        mp = (mp + 1) % 2;
        mc++;
        sb.push_back('{mp, mc});
    endtask

    task automatic pulse(input bit accepted);
        if (accepted) expect_move();
        @(negedge clk) move_req = 1'b1;
        @(negedge clk) move_req = 1'b0;
    endtask

    task automatic do_start(input bit from_end);
        if (from_end) mf = (mf + 1) % 2;
        mp = mf;
        mc = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Scoreboard consumer: every ack must match the oldest expected move.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (ack2 === 1'b1) begin
            compared++;
            assert (sb.size() > 0) else begin
                mismatched++;
                $error("FAIL unexpected_ack: observed ack at count %0d, expected no ack", cnt2);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("ack:cur", 32'(cur2), e.player);
                check("ack:count", 32'(cnt2), e.count);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; move_req = 1'b0; win2 = '0; win3 = '0;
        #1 reset = 1'b0;
        #1;
        check_state("rst", 0, 0);
        check("rst3:cur", 32'(cur3), 0);
        check("rst3:sel", 32'(sel3), 1);
        check("rst3:state", 32'(gs3), 0);
        @(negedge clk) reset = 1'b1;

        // IDLE ignores moves
        pulse(0);
        @(negedge clk);
        check_state("idle", 0, 0);

        do_start(0);
        check_state("start", 1, 0);
        check("start3:cur", 32'(cur3), 0);

        for (int i = 0; i < 4; i++) begin
            pulse(1);
            m3 = (m3 + 1) % 3;
            check($sformatf("p3_cur%0d", i), 32'(cur3), m3);
            check($sformatf("p3_sel%0d", i), 32'(sel3), 1 << m3);
            if (i == 2) check_state("move3", 1, 0);
        end
        check_state("move4", 1, 0);

        // Win on the same cycle as a move edge: edge dropped
        @(negedge clk) begin move_req = 1'b1; win2 = 2'b10; end
        @(negedge clk) begin move_req = 1'b0; win2 = 2'b00; end
        check_state("won", 2, 1);
        win2 = 2'b01;
        pulse(0);
        pulse(0);
        win2 = 2'b00;
        check_state("won_hold", 2, 1);

        do_start(1);
        check_state("restart", 1, 0);

        // Held request counts once
        expect_move();
        @(negedge clk) move_req = 1'b1;
        repeat (20) @(negedge clk);
        move_req = 1'b0;
        @(negedge clk);
        check_state("held", 1, 0);

        for (int i = 0; i < 8; i++) pulse(1);
        @(negedge clk);
        check_state("draw", 3, 0);
        pulse(0);
        @(negedge clk);
        check_state("draw_hold", 3, 0);

        do_start(1);
        check_state("restart2", 1, 0);

        // start beats win and move in PLAY; first player unchanged
        pulse(1);
        pulse(1);
        @(negedge clk) begin start = 1'b1; win2 = 2'b11; move_req = 1'b1; end
        @(negedge clk) begin start = 1'b0; win2 = 2'b00; move_req = 1'b0; end
        mc = 0;
        mp = mf;
        check_state("start_prio", 1, 0);

        @(negedge clk) win2 = 2'b11;
        @(negedge clk) win2 = 2'b00;
        check_state("won_low", 2, 0);

        do_start(1);
        for (int i = 0; i < 5; i++) pulse(1);
        check_state("count5", 1, 0);

        // Asynchronous reset mid-game
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        mp = 0; mc = 0; mf = 0;
        check_state("async_rst", 0, 0);
        check("async_rst:ack", 32'(ack2), 0);

        // move_req already high when reset releases is not an edge
        move_req = 1'b1;
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        do_start(0);
        repeat (2) @(negedge clk);
        check_state("no_edge", 1, 0);
        move_req = 1'b0;
        pulse(1);
        check_state("post_rst_move", 1, 0);

        repeat (2) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
